// File: rtl/aritmetica_pkg.sv
// Shared types and helpers for the arithmetic layer: multiplier FSM states
// and the width of the iteration counter.
package aritmetica_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } estado_mult_t;

  // Counter must represent 0..n so an overrun past the last iteration is visible.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sumador.sv
// Unsigned ripple adder with carry in; also flags two's-complement overflow
// for callers that interpret the operands as signed.
module sumador #(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic                Cin,
  output logic [NUM_BITS-1:0] S,
  output logic                C,
  output logic                V
);

  // Sum and carry out from one zero-extended addition.
  always_comb begin
    {C, S} = {1'b0, A} + {1'b0, B} + {{NUM_BITS{1'b0}}, Cin};
    V      = (A[NUM_BITS-1] == B[NUM_BITS-1]) && (S[NUM_BITS-1] != A[NUM_BITS-1]);
  end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Shift-and-add unsigned multiplier: one shared adder is reused over
// NUM_BITS cycles to build a 2*NUM_BITS-bit product behind a start/busy/done
// handshake.
module multiplicador_secuencial
  import aritmetica_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_BITS-1:0]   A,
  input  logic [NUM_BITS-1:0]   B,
  output logic                  busy,
  output logic                  done,
  output logic [2*NUM_BITS-1:0] P
);

  localparam int            CW   = count_w(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  estado_mult_t        state;
  logic [NUM_BITS-1:0] mcand;
  logic [NUM_BITS-1:0] acc_hi;
  logic [NUM_BITS-1:0] acc_lo;
  logic [CW-1:0]       count;

  logic [NUM_BITS-1:0] addend;
  logic [NUM_BITS-1:0] sum;
  logic                cout;
  logic                v_unused;
  logic [NUM_BITS-1:0] acc_hi_nxt;
  logic [NUM_BITS-1:0] acc_lo_nxt;

  // Partial product is the multiplicand gated by the current multiplier LSB.
  always_comb begin
    addend     = acc_lo[0] ? mcand : '0;
    acc_hi_nxt = {cout, sum[NUM_BITS-1:1]};
    acc_lo_nxt = {sum[0], acc_lo[NUM_BITS-1:1]};
  end

  sumador #(.NUM_BITS(NUM_BITS)) sumador_mult (
    .A  (acc_hi),
    .B  (addend),
    .Cin(1'b0),
    .S  (sum),
    .C  (cout),
    .V  (v_unused)
  );

  // Control FSM and accumulator shift register; busy/done/P are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      P      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (count > LAST) begin
            // Counter overran the iteration budget: abandon the operation.
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc_hi <= acc_hi_nxt;
            acc_lo <= acc_lo_nxt;
            count  <= count + CW'(1);
            if (count == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              P     <= {acc_hi_nxt, acc_lo_nxt};
              state <= FIN;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench for the sequential multiplier: stimulus pushes A*B and the
// expected done cycle, monitors pop and compare whenever done is seen.
module tb_multiplicador_secuencial;

  localparam int N  = 4;
  localparam int N8 = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start8;
  logic [N-1:0]  a, b;
  logic [N8-1:0] a8, b8;
  logic          busy, done, busy8, done8;
  logic [2*N-1:0]  p;
  logic [2*N8-1:0] p8;

  multiplicador_secuencial #(.NUM_BITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .P(p)
  );

  multiplicador_secuencial #(.NUM_BITS(N8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int exp;
    int at;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected actual P=%0d required=no done (cycle %0d)", p, cyc);
      end else begin
        e = q4.pop_front();
        chk("P4", int'(p), e.exp);
        chk("done4_cycle", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected actual P=%0d required=no done (cycle %0d)", p8, cyc);
      end else begin
        e = q8.pop_front();
        chk("P8", int'(p8), e.exp);
        chk("done8_cycle", cyc, e.at);
      end
    end
  end

  // Waits (bounded) until done is visible, scrambling the operand inputs so any
  // dependence on live A/B after capture shows up in P. Returns busy count.
  task automatic wait_done4(output int nb);
    int to;
    nb = 0;
    to = 0;
    while (!done && to < 40) begin
      if (busy) nb++;
      a = N'($urandom);
      b = N'($urandom);
      @(negedge clk);
      to++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done4_timeout actual=no done required=done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic op4(input int ai, input int bi, input int gap);
    int nb;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    a     = N'(ai);
    b     = N'(bi);
    start = 1'b1;
    q4.push_back('{ai * bi, cyc + N + 1});
    @(negedge clk);
    start = 1'b0;
    wait_done4(nb);
    chk("busy_cycles", nb, N);
    chk("busy_in_fin", int'(busy), 0);
  endtask

  task automatic op8(input int ai, input int bi);
    int to;
    @(negedge clk);
    a8     = N8'(ai);
    b8     = N8'(bi);
    start8 = 1'b1;
    q8.push_back('{ai * bi, cyc + N8 + 1});
    @(negedge clk);
    start8 = 1'b0;
    to = 0;
    while (!done8 && to < 60) begin
      @(negedge clk);
      to++;
    end
    if (!done8) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout actual=no done required=done within 60 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    int nb;
    rst_n  = 1'b0;
    start  = 1'b0;
    start8 = 1'b0;
    a  = '0; b  = '0;
    a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_P", int'(p), 0);
    chk("rst_P8", int'(p8), 0);
    rst_n = 1'b1;

    op4(13, 11, 0);
    op4(15, 15, 0);
    op4(0, 9, 0);
    op4(7, 0, 0);

    // start held high: FIN and CALC must ignore it; relaunch only from IDLE
    @(negedge clk);
    a     = 4'd3;
    b     = 4'd5;
    start = 1'b1;
    q4.push_back('{15, cyc + N + 1});
    @(negedge clk);
    wait_done4(nb);
    chk("held_busy_cycles", nb, N);
    a = 4'd6;
    b = 4'd7;
    q4.push_back('{42, cyc + N + 2});
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done4(nb);

    // reset during the second CALC cycle discards the operation
    @(negedge clk);
    a     = 4'd9;
    b     = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_P", int'(p), 0);
    rst_n = 1'b1;
    op4(2, 3, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(i, j, 0);

    for (int k = 0; k < 40; k++)
      op4(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));

    op8(255, 255);
    op8(0, 200);
    for (int k = 0; k < 6; k++)
      op8(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));

    repeat (4) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
